// File: rtl/ga_mutation_ctrl.sv
// Mutation-stage controller for the genetic-algorithm pipeline.
// Each child from crossover is accepted in IDLE. The random draw against the
// mutation rate selects it for mutation, which runs cnfg_mut_num rounds
// through the external datapath. The result is then held in OUT until the
// downstream queue takes it.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a child; in_ready=1
// MUTATE | one datapath round per cycle, rnd_cnt rounds remaining
// OUT    | result held on out_chrom_ary with out_valid=1 until out_ready
module ga_mutation_ctrl #(
  parameter int DATA_W    = 8,
  parameter int M_MAX     = 8,
  parameter int P_MAX_W   = 7,
  parameter int RATE_W    = 8,
  parameter int MUT_NUM_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RATE_W-1:0]         cnfg_mut_rate,
  input  logic [MUT_NUM_W-1:0]      cnfg_mut_num,
  input  logic [P_MAX_W-1:0]        cnfg_p,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W*M_MAX-1:0]   in_child_ary,
  input  logic [RATE_W-1:0]         rand_rate,
  output logic [DATA_W*M_MAX-1:0]   alg_child_ary,
  input  logic [DATA_W*M_MAX-1:0]   alg_queue_chrom_ary,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W*M_MAX-1:0]   out_chrom_ary,
  output logic                      out_mutated,
  output logic                      gen_done_pls
);

  localparam int CHROM_W = DATA_W * M_MAX;
  localparam logic [P_MAX_W-1:0]   P_ONE   = 1;
  localparam logic [MUT_NUM_W-1:0] RND_ONE = 1;

  typedef enum logic [1:0] {IDLE, MUTATE, OUT} state_t;

  state_t               state, state_nxt;
  logic [CHROM_W-1:0]   work_reg;
  logic [MUT_NUM_W-1:0] rnd_cnt;
  logic                 mut_flag;
  logic                 mutated_r;
  logic [P_MAX_W-1:0]   child_cnt;
  logic [P_MAX_W-1:0]   p_reg;
  logic                 rate_hit;
  logic                 out_hs;
  logic                 last_child;

  assign rate_hit      = (rand_rate < cnfg_mut_rate);
  assign alg_child_ary = work_reg;
  assign out_chrom_ary = work_reg;
  assign out_mutated   = mutated_r;
  assign last_child    = (p_reg != '0) && (child_cnt == p_reg - P_ONE);

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_hs       = 1'b0;
    gen_done_pls = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (rate_hit && (cnfg_mut_num != '0)) state_nxt = MUTATE;
          else                                  state_nxt = OUT;
        end
      end
      MUTATE: begin
        if (rnd_cnt <= RND_ONE) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_hs       = 1'b1;
          gen_done_pls = last_child;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, working chromosome, round counter and child counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work_reg  <= '0;
      rnd_cnt   <= '0;
      mut_flag  <= 1'b0;
      mutated_r <= 1'b0;
      child_cnt <= '0;
      p_reg     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= in_child_ary;
            rnd_cnt   <= cnfg_mut_num;
            mut_flag  <= rate_hit;
            p_reg     <= cnfg_p;
            mutated_r <= 1'b0;
          end
        end
        MUTATE: begin
          work_reg <= alg_queue_chrom_ary;
          rnd_cnt  <= rnd_cnt - RND_ONE;
          if (rnd_cnt <= RND_ONE) mutated_r <= mut_flag;
        end
        OUT: begin
          if (out_hs) begin
            if (last_child) child_cnt <= '0;
            else            child_cnt <= child_cnt + P_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ga_mutation_ctrl.sv
// Directed bench for ga_mutation_ctrl. Inputs change and outputs are sampled
// on the falling edge; the mutation datapath is modelled as an XOR of
// element 0 with 0x01.
module tb_ga_mutation_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cnfg_mut_rate;
  logic [3:0]  cnfg_mut_num;
  logic [6:0]  cnfg_p;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_child_ary;
  logic [7:0]  rand_rate;
  logic [63:0] alg_child_ary;
  logic [63:0] alg_queue_chrom_ary;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_chrom_ary;
  logic        out_mutated;
  logic        gen_done_pls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alg_queue_chrom_ary = alg_child_ary ^ 64'h01;

  ga_mutation_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .cnfg_mut_rate       (cnfg_mut_rate),
    .cnfg_mut_num        (cnfg_mut_num),
    .cnfg_p              (cnfg_p),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_child_ary        (in_child_ary),
    .rand_rate           (rand_rate),
    .alg_child_ary       (alg_child_ary),
    .alg_queue_chrom_ary (alg_queue_chrom_ary),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_chrom_ary       (out_chrom_ary),
    .out_mutated         (out_mutated),
    .gen_done_pls        (gen_done_pls)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  localparam logic [63:0] C1 = 64'h0807060504030201;
  localparam logic [63:0] C2 = 64'h1122334455667788;
  localparam logic [63:0] C3 = 64'hA5A5A5A55A5A5A5A;
  localparam logic [63:0] C4 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] C5 = 64'h0123456789ABCDEF;

  logic saw_valid;

  initial begin
    rst = 1'b1; cnfg_mut_rate = 8'd0; cnfg_mut_num = 4'd0; cnfg_p = 7'd0;
    in_valid = 1'b0; in_child_ary = '0; rand_rate = 8'd0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mutated", out_mutated, 0);
    chk("rst_gen_done", gen_done_pls, 0);
    chk("rst_out_chrom", out_chrom_ary, 0);
    tick();

    // No mutation, rate 0
    in_valid = 1'b1; in_child_ary = C1; rand_rate = 8'd0; cnfg_mut_num = 4'd3;
    tick();
    in_valid = 1'b0;
    chk("nomut_valid", out_valid, 1);
    chk("nomut_in_ready", in_ready, 0);
    chk("nomut_chrom", out_chrom_ary, C1);
    chk("nomut_mutated", out_mutated, 0);
    chk("nomut_gen_done_p0", gen_done_pls, 0);
    tick();
    chk("nomut_back_idle", in_ready, 1);
    chk("nomut_valid_low", out_valid, 0);

    // Three rounds; config changed mid-child must not matter
    cnfg_mut_rate = 8'd255; rand_rate = 8'd0; cnfg_mut_num = 4'd3;
    in_valid = 1'b1; in_child_ary = C2;
    tick();
    in_valid = 1'b0; cnfg_mut_rate = 8'd0; cnfg_mut_num = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk("mut3_in_ready", in_ready, 0);
      chk("mut3_valid_low", out_valid, 0);
      tick();
    end
    chk("mut3_valid", out_valid, 1);
    chk("mut3_chrom", out_chrom_ary, C2 ^ 64'h01);
    chk("mut3_mutated", out_mutated, 1);
    chk("mut3_in_ready_out", in_ready, 0);
    tick();
    chk("mut3_back_idle", in_ready, 1);

    // Zero rounds with flag set
    cnfg_mut_rate = 8'd255; rand_rate = 8'd0; cnfg_mut_num = 4'd0;
    in_valid = 1'b1; in_child_ary = C3;
    tick();
    in_valid = 1'b0;
    chk("zero_valid", out_valid, 1);
    chk("zero_chrom", out_chrom_ary, C3);
    chk("zero_mutated", out_mutated, 0);
    tick();

    // Rate all-ones, draw all-ones: no mutation
    cnfg_mut_rate = 8'd255; rand_rate = 8'd255; cnfg_mut_num = 4'd3;
    in_valid = 1'b1; in_child_ary = C5;
    tick();
    in_valid = 1'b0;
    chk("maxrate_valid", out_valid, 1);
    chk("maxrate_chrom", out_chrom_ary, C5);
    chk("maxrate_mutated", out_mutated, 0);
    tick();

    // Backpressure for 10 cycles with a second child waiting
    cnfg_mut_rate = 8'd0; out_ready = 1'b0;
    in_valid = 1'b1; in_child_ary = C4;
    tick();
    in_child_ary = C5;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_chrom", out_chrom_ary, C4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_chrom", out_chrom_ary, C5);
    tick();

    // Generation end with cnfg_p = 4
    rst = 1'b1;
    tick();
    rst = 1'b0; cnfg_p = 7'd4; cnfg_mut_rate = 8'd0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_child_ary = C1 + 64'(k);
      tick();
      in_valid = 1'b0;
      chk("gen_valid", out_valid, 1);
      chk("gen_done", gen_done_pls, (k == 3) ? 1 : 0);
      tick();
      chk("gen_done_idle", gen_done_pls, 0);
    end

    // Reset during MUTATE
    cnfg_mut_rate = 8'd255; rand_rate = 8'd0; cnfg_mut_num = 4'd15;
    in_valid = 1'b1; in_child_ary = C2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstmut_in_ready", in_ready, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmut_in_ready_after", in_ready, 1);
    chk("rstmut_valid_after", out_valid, 0);
    chk("rstmut_chrom_after", out_chrom_ary, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    chk("rstmut_no_output", saw_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
